// File: rtl/npc_pkg.sv
// Shared npc definitions: AXI response codes, physical memory map and the
// state encoding of the AXI4-Lite memory responder.
package npc_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [31:0] PMEM_BASE = 32'h8000_0000;
  localparam logic [31:0] PMEM_SIZE = 32'h0800_0000;

  typedef enum logic [2:0] {
    StIdle,
    StRdWait,
    StRdResp,
    StWrWait,
    StWrResp
  } sram_state_t;

  // 33-bit offset so an address below base becomes huge instead of wrapping into range.
  function automatic logic addr_in_range(logic [31:0] addr, logic [31:0] base,
                                         logic [31:0] size);
    logic [32:0] off;
    off = {1'b0, addr} - {1'b0, base};
    return off < {1'b0, size};
  endfunction

endpackage

// File: rtl/delay_counter.sv
// 8-bit loadable down-counter; holds at zero and flags it combinationally.
module delay_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] load_val,
  output logic       zero
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != 8'd0)) begin
      count_d = count_q - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == 8'd0);

endmodule

// File: rtl/sram_axil.sv
// AXI4-Lite memory responder with programmable access latency. The single
// memory access per transaction is exported on the pmem_* port for the simulator.
module sram_axil
  import npc_pkg::*;
#(
  parameter logic [31:0] BASE    = PMEM_BASE,
  parameter logic [31:0] SIZE    = PMEM_SIZE,
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  output logic        pmem_ren,
  output logic        pmem_wen,
  output logic [31:0] pmem_addr,
  output logic [31:0] pmem_wdata,
  output logic [7:0]  pmem_wmask,
  input  logic [31:0] pmem_rdata
);

  localparam logic [7:0] LatVal = 8'(LATENCY);

  sram_state_t state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        rvalid_q, rvalid_d;
  logic        bvalid_q, bvalid_d;
  logic        cnt_load, cnt_en, cnt_zero;
  logic        idle, hit;

  delay_counter u_delay_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (LatVal),
    .zero     (cnt_zero)
  );

  // Readies are gated by rst so nothing looks acceptable while reset is held.
  assign idle    = (state_q == StIdle) && rst;
  assign arready = idle;
  assign awready = idle && !arvalid;
  assign wready  = idle && !arvalid;
  assign hit     = addr_in_range(addr_q, BASE, SIZE);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    bresp_d  = bresp_q;
    rvalid_d = rvalid_q;
    bvalid_d = bvalid_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    pmem_ren = 1'b0;
    pmem_wen = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arvalid) begin
          addr_d   = araddr;
          cnt_load = 1'b1;
          state_d  = StRdWait;
        end else if (awvalid && wvalid) begin
          addr_d   = awaddr;
          wdata_d  = wdata;
          wstrb_d  = wstrb;
          cnt_load = 1'b1;
          state_d  = StWrWait;
        end
      end
      StRdWait: begin
        if (cnt_zero) begin
          pmem_ren = hit;
          rdata_d  = hit ? pmem_rdata : 32'h0;
          rresp_d  = hit ? RESP_OKAY : RESP_SLVERR;
          rvalid_d = 1'b1;
          state_d  = StRdResp;
        end else begin
          cnt_en = 1'b1;
        end
      end
      StRdResp: begin
        if (rready) begin
          rvalid_d = 1'b0;
          state_d  = StIdle;
        end
      end
      StWrWait: begin
        if (cnt_zero) begin
          // An all-zero strobe is a legal no-op, so it answers OKAY without touching memory.
          pmem_wen = hit && (wstrb_q != 4'b0000);
          bresp_d  = hit ? RESP_OKAY : RESP_SLVERR;
          bvalid_d = 1'b1;
          state_d  = StWrResp;
        end else begin
          cnt_en = 1'b1;
        end
      end
      StWrResp: begin
        if (bready) begin
          bvalid_d = 1'b0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      wstrb_q  <= 4'h0;
      rdata_q  <= 32'h0;
      rresp_q  <= RESP_OKAY;
      bresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      bvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      bvalid_q <= bvalid_d;
    end
  end

  assign rdata      = rdata_q;
  assign rresp      = rresp_q;
  assign rvalid     = rvalid_q;
  assign bresp      = bresp_q;
  assign bvalid     = bvalid_q;
  assign pmem_addr  = {addr_q[31:2], 2'b00};
  assign pmem_wdata = wdata_q;
  assign pmem_wmask = {4'b0000, wstrb_q};

endmodule

// File: tb/tb_sram_axil.sv
// Directed bench for sram_axil: LATENCY=2 instance against a small word memory,
// plus a LATENCY=5 instance for the reset-during-write case.
module tb_sram_axil;

  logic        clk = 1'b0;
  logic        rst, l5_rst;
  logic [31:0] araddr, awaddr, wdata, rdata, pmem_addr, pmem_wdata, pmem_rdata;
  logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready;
  logic        bvalid, bready, pmem_ren, pmem_wen;
  logic [3:0]  wstrb;
  logic [1:0]  rresp, bresp;
  logic [7:0]  pmem_wmask;

  logic [31:0] l5_araddr, l5_awaddr, l5_wdata, l5_rdata, l5_pmem_addr, l5_pmem_wdata;
  logic        l5_arvalid, l5_arready, l5_rvalid, l5_rready, l5_awvalid, l5_awready;
  logic        l5_wvalid, l5_wready, l5_bvalid, l5_bready, l5_pmem_ren, l5_pmem_wen;
  logic [3:0]  l5_wstrb;
  logic [1:0]  l5_rresp, l5_bresp;
  logic [7:0]  l5_pmem_wmask;

  logic [31:0] mem [256];
  logic        tb_clr, tb_pre_en;
  logic [7:0]  tb_pre_idx;
  logic [31:0] tb_pre_data;
  int          rd_count, wr_count, l5_wr_count;
  int          errors, checks;

  always #5 clk = ~clk;

  sram_axil #(.LATENCY(2)) u_dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .pmem_ren(pmem_ren), .pmem_wen(pmem_wen), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_wmask(pmem_wmask), .pmem_rdata(pmem_rdata)
  );

  sram_axil #(.LATENCY(5)) u_dut_l5 (
    .clk(clk), .rst(l5_rst),
    .araddr(l5_araddr), .arvalid(l5_arvalid), .arready(l5_arready),
    .rdata(l5_rdata), .rresp(l5_rresp), .rvalid(l5_rvalid), .rready(l5_rready),
    .awaddr(l5_awaddr), .awvalid(l5_awvalid), .awready(l5_awready),
    .wdata(l5_wdata), .wstrb(l5_wstrb), .wvalid(l5_wvalid), .wready(l5_wready),
    .bresp(l5_bresp), .bvalid(l5_bvalid), .bready(l5_bready),
    .pmem_ren(l5_pmem_ren), .pmem_wen(l5_pmem_wen), .pmem_addr(l5_pmem_addr),
    .pmem_wdata(l5_pmem_wdata), .pmem_wmask(l5_pmem_wmask), .pmem_rdata(32'h0)
  );

  // Memory model: 1 KiB window at 0x80000000, reads elsewhere return 0.
  assign pmem_rdata = (pmem_addr[31:10] == 22'h200000) ? mem[pmem_addr[9:2]] : 32'h0;

  always @(posedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    end else if (tb_pre_en) begin
      mem[tb_pre_idx] = tb_pre_data;
    end
    if (pmem_ren) rd_count++;
    if (pmem_wen) begin
      wr_count++;
      if (pmem_addr[31:10] == 22'h200000) begin
        for (int b = 0; b < 4; b++)
          if (pmem_wmask[b]) mem[pmem_addr[9:2]][b*8 +: 8] = pmem_wdata[b*8 +: 8];
      end
    end
    if (l5_pmem_wen) l5_wr_count++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r,
                         output logic ok);
    araddr  = a;
    arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    for (int i = 0; i < 20 && !rvalid; i++) begin
      @(posedge clk); #1;
    end
    ok     = rvalid;
    d      = rdata;
    r      = rresp;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] r, output logic ok);
    awaddr  = a;
    wdata   = d;
    wstrb   = s;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    for (int i = 0; i < 20 && !bvalid; i++) begin
      @(posedge clk); #1;
    end
    ok     = bvalid;
    r      = bresp;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic        ok;

    errors = 0; checks = 0;
    rd_count = 0; wr_count = 0; l5_wr_count = 0;
    rst = 1'b0; l5_rst = 1'b0;
    araddr = 32'h8000_0006; arvalid = 1'b1; rready = 1'b0;
    awaddr = 32'h0; awvalid = 1'b0; wdata = 32'h0; wstrb = 4'h0; wvalid = 1'b0; bready = 1'b0;
    l5_araddr = 32'h0; l5_arvalid = 1'b0; l5_rready = 1'b0;
    l5_awaddr = 32'h0; l5_awvalid = 1'b0; l5_wdata = 32'h0; l5_wstrb = 4'h0;
    l5_wvalid = 1'b0; l5_bready = 1'b0;
    tb_clr = 1'b1; tb_pre_en = 1'b0; tb_pre_idx = 8'd0; tb_pre_data = 32'h0;

    // Reset held three cycles with arvalid high; memory initialised meanwhile.
    @(posedge clk); #1;
    tb_clr = 1'b0; tb_pre_en = 1'b1; tb_pre_idx = 8'd1; tb_pre_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    tb_pre_en = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready", {29'd0, arready, awready, wready}, 32'h0);
    chk("rst_valid", {30'd0, rvalid, bvalid}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_resp", {28'd0, rresp, bresp}, 32'h0);
    rst = 1'b1; l5_rst = 1'b1;
    #1;
    chk("post_rst_arready", arready, 32'h1);

    // LATENCY=2 read of unaligned 0x80000006 -> word 0x80000004.
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("ar_accepted", arready, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      chk("rd_latency", rvalid, (k == 3) ? 32'h1 : 32'h0);
    end
    chk("rd_data", rdata, 32'hDEAD_BEEF);
    chk("rd_resp", rresp, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("rd_hold_valid", rvalid, 32'h1);
      chk("rd_hold_data", rdata, 32'hDEAD_BEEF);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    chk("rd_done_valid", rvalid, 32'h0);
    chk("rd_done_idle", arready, 32'h1);
    chk("rd_count1", rd_count, 32'd1);

    // Byte-lane write then readback.
    do_write(32'h8000_0010, 32'h1122_3344, 4'b0101, r, ok);
    chk("bw_ok", ok, 32'h1);
    chk("bw_resp", r, 32'h0);
    chk("bw_count", wr_count, 32'd1);
    chk("bw_mem", mem[4], 32'h0022_0044);
    do_read(32'h8000_0010, d, r, ok);
    chk("bw_rb_ok", ok, 32'h1);
    chk("bw_rb_data", d, 32'h0022_0044);

    // Simultaneous AR and AW+W: read first, write in the following IDLE cycle.
    araddr = 32'h8000_0004; arvalid = 1'b1;
    awaddr = 32'h8000_0008; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    #1;
    chk("arb_arready", arready, 32'h1);
    chk("arb_awready", {awready, wready}, 32'h0);
    @(posedge clk); #1;
    arvalid = 1'b0;
    for (int i = 0; i < 20 && !rvalid; i++) begin
      @(posedge clk); #1;
    end
    chk("arb_rvalid", rvalid, 32'h1);
    chk("arb_rdata", rdata, 32'hDEAD_BEEF);
    chk("arb_no_bvalid", bvalid, 32'h0);
    chk("arb_wr_pending", wr_count, 32'd1);
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    chk("arb_aw_now", {awready, wready}, 32'h3);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 20 && !bvalid; i++) begin
      @(posedge clk); #1;
    end
    chk("arb_bvalid", bvalid, 32'h1);
    chk("arb_bresp", bresp, 32'h0);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    chk("arb_wr_count", wr_count, 32'd2);
    chk("arb_mem", mem[2], 32'hCAFE_F00D);
    chk("arb_rd_count", rd_count, 32'd3);

    // Out-of-range accesses and zero-strobe write: no memory traffic.
    do_read(32'h7FFF_FFFC, d, r, ok);
    chk("oor_rd_ok", ok, 32'h1);
    chk("oor_rd_resp", r, 32'h2);
    chk("oor_rd_data", d, 32'h0);
    do_read(32'hFFFF_FFFC, d, r, ok);
    chk("oor_hi_resp", r, 32'h2);
    do_read(32'h87FF_FFFC, d, r, ok);
    chk("top_word_resp", r, 32'h0);
    chk("oor_rd_count", rd_count, 32'd4);
    do_write(32'h8800_0000, 32'h5555_5555, 4'hF, r, ok);
    chk("oor_wr_ok", ok, 32'h1);
    chk("oor_wr_resp", r, 32'h2);
    do_write(32'h8000_0010, 32'hFFFF_FFFF, 4'h0, r, ok);
    chk("strb0_resp", r, 32'h0);
    chk("oor_wr_count", wr_count, 32'd2);
    chk("strb0_mem", mem[4], 32'h0022_0044);

    // LATENCY=5 instance: reset while the write is still counting down.
    l5_awaddr = 32'h8000_0020; l5_wdata = 32'h1234_5678; l5_wstrb = 4'hF;
    l5_awvalid = 1'b1; l5_wvalid = 1'b1;
    #1;
    chk("l5_awready", l5_awready, 32'h1);
    @(posedge clk); #1;
    l5_awvalid = 1'b0; l5_wvalid = 1'b0;
    @(posedge clk); #1;
    l5_rst = 1'b0;
    #1;
    chk("l5_rst_bvalid", l5_bvalid, 32'h0);
    chk("l5_rst_ready", {l5_arready, l5_awready}, 32'h0);
    repeat (8) @(posedge clk);
    #1;
    chk("l5_rst_no_write", l5_wr_count, 32'd0);
    l5_rst = 1'b1;
    #1;
    chk("l5_idle_after", {l5_arready, l5_awready, l5_wready}, 32'h7);
    repeat (8) @(posedge clk);
    #1;
    chk("l5_still_no_write", l5_wr_count, 32'd0);
    chk("l5_bvalid_after", l5_bvalid, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
